// File: rtl/pps_capture_pkg.sv
// pps_capture_pkg: shared definitions for the PPS-input capture block.
//   RTC_W / SEC_W / NS_W : RTC time width and its seconds:nanoseconds split
//   pps_state_t          : capture state machine encoding
//   MIN_HIGH_LO/HI       : legal range of the MIN_HIGH qualifier
package pps_capture_pkg;

  localparam int unsigned RTC_W = 80;
  localparam int unsigned SEC_W = 48;
  localparam int unsigned NS_W  = 32;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
  } rtc_t;

  localparam int unsigned MIN_HIGH_LO = 1;
  localparam int unsigned MIN_HIGH_HI = 255;

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_ARMED    = 2'd1,
    ST_QUAL     = 2'd2,
    ST_HOLD     = 2'd3
  } pps_state_t;

  function automatic int unsigned clamp_min_high(input int unsigned v);
    if (v < MIN_HIGH_LO) return MIN_HIGH_LO;
    if (v > MIN_HIGH_HI) return MIN_HIGH_HI;
    return v;
  endfunction

endpackage

// File: rtl/pps_capture_if.sv
// pps_capture_if: register-block side of the PPS capture unit.
//   master : register block (drives clr_i / rd_i, observes status and head)
//   slave  : pps_capture
interface pps_capture_if;
  import pps_capture_pkg::*;

  logic             clr_i;
  logic             rd_i;
  logic [RTC_W-1:0] ts_o;
  logic             ts_vld_o;
  logic [3:0]       cnt_o;
  logic             ovf_o;
  logic [7:0]       glitch_cnt_o;
  logic             irq_o;

  modport master (
    output clr_i, rd_i,
    input  ts_o, ts_vld_o, cnt_o, ovf_o, glitch_cnt_o, irq_o
  );

  modport slave (
    input  clr_i, rd_i,
    output ts_o, ts_vld_o, cnt_o, ovf_o, glitch_cnt_o, irq_o
  );
endinterface

// File: rtl/pps_capture_ts_fifo.sv
// ts_fifo: show-ahead timestamp FIFO with registered head output.
//   i_flush  : synchronous flush, overrides push/pop
//   i_push   : write request, i_din data
//   i_pop    : pop head (ignored when empty)
//   o_dout   : registered head, valid while o_vld
//   o_cnt    : occupancy 0..DEPTH
//   o_push_ok: a write was accepted this cycle
//   o_drop   : a write was refused because the FIFO was full
module ts_fifo #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_vld,
  output logic [3:0]       o_cnt,
  output logic             o_push_ok,
  output logic             o_drop
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             w_empty, w_full, w_pop, w_push;
  logic [AW:0]      w_cnt;
  logic [AW-1:0]    w_rd_nxt;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_cnt    = r_wptr - r_rptr;
  assign w_rd_nxt = r_rptr[AW-1:0] + 1'b1;

  assign w_pop  = i_pop && !w_empty && !i_flush;
  // Full with a pop in the same cycle frees the slot being written.
  assign w_push = i_push && (!w_full || w_pop) && !i_flush;

  assign o_drop    = i_push && w_full && !w_pop && !i_flush;
  assign o_push_ok = w_push;
  assign o_vld     = !w_empty;
  assign o_cnt     = 4'(w_cnt);
  assign o_dout    = r_dout;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // Head register tracks what the head will be after this cycle.
      if (w_push && w_empty)
        r_dout <= i_din;
      else if (w_pop)
        r_dout <= (w_push && (w_cnt == (AW+1)'(1))) ? i_din : r_mem[w_rd_nxt];
    end
  end
endmodule

// File: rtl/pps_capture.sv
// pps_capture: synchronizes and qualifies an external PPS input and latches
// the RTC time at the qualified rising edge into a small timestamp FIFO.
//   clk, rst_n : core clock / async active-low reset
//   pps_i      : external PPS (asynchronous)
//   rtc_std_i  : current RTC time {sec[47:0], ns[31:0]}
//   cap_en_i   : capture enable (gates arming only)
//   bus        : register-block port (clr/rd in; head, status, irq out)
module pps_capture
  import pps_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pps_i,
  input  logic [RTC_W-1:0] rtc_std_i,
  input  logic             cap_en_i,
  pps_capture_if.slave     bus
);
  localparam logic [7:0] MH = 8'(clamp_min_high(MIN_HIGH));

  logic [SYNC_STAGES-1:0] r_sync;
  logic [RTC_W-1:0]       r_dly [SYNC_STAGES];
  pps_state_t             r_state;
  logic [7:0]             r_hi_cnt;
  logic [7:0]             r_glitch_cnt;
  logic [RTC_W-1:0]       r_pend_ts;
  logic                   r_commit;
  logic                   r_ovf;
  logic                   r_irq;

  logic                   w_pps_s;
  logic [RTC_W-1:0]       w_aligned;
  logic                   w_glitch;
  logic                   w_push_ok, w_drop;

  assign w_pps_s   = r_sync[SYNC_STAGES-1];
  assign w_aligned = r_dly[SYNC_STAGES-1];
  assign w_glitch  = (r_state == ST_QUAL) && !w_pps_s;

  // Synchronizer resets to ones so the reset state never reads as a low;
  // a pps_i held high across reset release is therefore not captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_dly[i] <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], pps_i};
      r_dly[0] <= rtc_std_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_WAIT_LOW;
      r_hi_cnt     <= '0;
      r_pend_ts    <= '0;
      r_commit     <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      r_commit <= 1'b0;
      if (bus.clr_i)
        r_glitch_cnt <= '0;
      else if (w_glitch && (r_glitch_cnt != 8'hFF))
        r_glitch_cnt <= r_glitch_cnt + 8'd1;

      unique case (r_state)
        ST_WAIT_LOW: if (!w_pps_s && cap_en_i) r_state <= ST_ARMED;
        ST_ARMED: begin
          if (!cap_en_i)
            r_state <= ST_WAIT_LOW;
          else if (w_pps_s) begin
            r_pend_ts <= w_aligned;
            r_hi_cnt  <= 8'd1;
            if (MH == 8'd1) begin
              r_commit <= 1'b1;
              r_state  <= ST_HOLD;
            end else begin
              r_state  <= ST_QUAL;
            end
          end
        end
        ST_QUAL: begin
          if (w_pps_s) begin
            r_hi_cnt <= r_hi_cnt + 8'd1;
            if (r_hi_cnt + 8'd1 == MH) begin
              r_commit <= 1'b1;
              r_state  <= ST_HOLD;
            end
          end else begin
            r_state <= ST_ARMED;
          end
        end
        ST_HOLD: if (!w_pps_s) r_state <= ST_WAIT_LOW;
        default: r_state <= ST_WAIT_LOW;
      endcase
    end
  end

  ts_fifo #(
    .WIDTH(RTC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (bus.clr_i),
    .i_push    (r_commit),
    .i_din     (r_pend_ts),
    .i_pop     (bus.rd_i),
    .o_dout    (bus.ts_o),
    .o_vld     (bus.ts_vld_o),
    .o_cnt     (bus.cnt_o),
    .o_push_ok (w_push_ok),
    .o_drop    (w_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_push_ok;
      if (bus.clr_i)   r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign bus.ovf_o        = r_ovf;
  assign bus.irq_o        = r_irq;
  assign bus.glitch_cnt_o = r_glitch_cnt;
endmodule

// File: tb/tb_pps_capture.sv
// tb_pps_capture: directed stimulus for pps_capture with a cycle-level
// reference model (pulse run-length detector + queue FIFO) checked after
// every clock edge, plus hand-computed literal expectations.
module tb_pps_capture;
  import pps_capture_pkg::*;

  localparam int unsigned S = 2;
  localparam int unsigned M = 8;
  localparam int unsigned D = 4;
  localparam logic [79:0] BASE = 80'h11_2222_3333_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps_i = 1'b0;
  logic        cap_en_i = 1'b0;
  logic [79:0] rtc_std_i = '0;

  pps_capture_if bus();

  pps_capture #(
    .SYNC_STAGES(S),
    .MIN_HIGH   (M),
    .FIFO_DEPTH (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pps_i    (pps_i),
    .rtc_std_i(rtc_std_i),
    .cap_en_i (cap_en_i),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [79:0] m_q[$];
  bit          m_ovf, m_irq;
  int          m_glitch;
  bit          pps_h [S+1];
  logic [79:0] rtc_h [S+1];
  bit          m_ready, m_hold, m_cn;
  int          m_run;
  logic [79:0] m_pend, m_cv;

  bit          p, cn_now, pop, push, ge;
  logic [79:0] al;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_irq = 0; m_glitch = 0;
    for (int i = 0; i <= S; i++) begin pps_h[i] = 1; rtc_h[i] = '0; end
    m_ready = 0; m_hold = 0; m_cn = 0; m_run = 0; m_pend = '0; m_cv = '0;
  endtask

  initial model_reset();

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = S; i >= 1; i--) begin pps_h[i] = pps_h[i-1]; rtc_h[i] = rtc_h[i-1]; end
      pps_h[0] = pps_i;
      rtc_h[0] = rtc_std_i;
      p  = pps_h[S];
      al = rtc_h[S];

      // FIFO effect of the commit decided on the previous edge
      cn_now = m_cn; m_cn = 0; m_irq = 0; push = 0; pop = 0;
      if (bus.clr_i) begin
        m_q.delete();
        m_ovf = 0;
      end else begin
        pop = bus.rd_i && (m_q.size() > 0);
        if (cn_now) begin
          if (m_q.size() < D || pop) push = 1;
          else m_ovf = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin m_q.push_back(m_cv); m_irq = 1; end
      end

      // pulse qualification by high run length
      ge = 0;
      if (m_run > 0) begin
        if (p) begin
          m_run++;
          if (m_run == M) begin m_cn = 1; m_cv = m_pend; m_run = 0; m_hold = 1; end
        end else begin
          ge = 1; m_run = 0; m_ready = 1;
        end
      end else if (m_hold) begin
        if (!p) begin m_hold = 0; m_ready = 0; end
      end else if (m_ready) begin
        if (!cap_en_i) m_ready = 0;
        else if (p) begin
          m_pend = al; m_run = 1;
          if (m_run == M) begin m_cn = 1; m_cv = m_pend; m_run = 0; m_hold = 1; end
        end
      end else if (!p && cap_en_i) begin
        m_ready = 1;
      end
      if (ge && m_glitch < 255) m_glitch++;
      if (bus.clr_i) m_glitch = 0;
    end

    chk("vld",    80'(bus.ts_vld_o),     80'(m_q.size() > 0));
    chk("cnt",    80'(bus.cnt_o),        80'(m_q.size()));
    chk("ovf",    80'(bus.ovf_o),        80'(m_ovf));
    chk("glitch", 80'(bus.glitch_cnt_o), 80'(m_glitch));
    chk("irq",    80'(bus.irq_o),        80'(m_irq));
    if (m_q.size() > 0) chk("ts", bus.ts_o, m_q[0]);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      rtc_std_i = rtc_std_i + 80'd1;
    end
  endtask

  task automatic pulse(input int hi, input int lo, output logic [79:0] ts);
    pps_i = 1'b1;
    ts = rtc_std_i;
    tick(hi);
    pps_i = 1'b0;
    tick(lo);
  endtask

  task automatic clr();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
  endtask

  logic [79:0] tsv [5];
  logic [79:0] t;

  initial begin
    bus.clr_i = 1'b0;
    bus.rd_i  = 1'b0;
    cap_en_i  = 1'b1;
    tick(3);
    chk("rst_vld", 80'(bus.ts_vld_o), 80'd0);
    chk("rst_cnt", 80'(bus.cnt_o), 80'd0);
    chk("rst_ts",  bus.ts_o, 80'd0);

    // single 20-cycle pulse
    rst_n = 1'b1;
    rtc_std_i = BASE;
    tick(5);
    pps_i = 1'b1;
    tick(10);
    chk("t1_vld_early", 80'(bus.ts_vld_o), 80'd0);
    tick();
    chk("t1_vld_e10", 80'(bus.ts_vld_o), 80'd1);
    chk("t1_irq", 80'(bus.irq_o), 80'd1);
    chk("t1_ts_lit", bus.ts_o, 80'h11_2222_3333_0000_0005);
    tick();
    chk("t1_irq_once", 80'(bus.irq_o), 80'd0);
    tick(8);
    pps_i = 1'b0;
    tick(8);
    chk("t1_cnt", 80'(bus.cnt_o), 80'd1);

    // 7-cycle glitch then 8-cycle pulse
    clr();
    chk("t2_clr_cnt", 80'(bus.cnt_o), 80'd0);
    pulse(7, 6, t);
    pulse(8, 8, t);
    chk("t2_glitch", 80'(bus.glitch_cnt_o), 80'd1);
    chk("t2_cnt", 80'(bus.cnt_o), 80'd1);
    chk("t2_ts", bus.ts_o, t);

    // overflow
    clr();
    for (int i = 0; i < 5; i++) pulse(10, 6, tsv[i]);
    chk("t3_cnt", 80'(bus.cnt_o), 80'd4);
    chk("t3_ovf", 80'(bus.ovf_o), 80'd1);
    chk("t3_head", bus.ts_o, tsv[0]);
    clr();
    chk("t3_clr_cnt", 80'(bus.cnt_o), 80'd0);
    chk("t3_clr_ovf", 80'(bus.ovf_o), 80'd0);
    chk("t3_clr_glitch", 80'(bus.glitch_cnt_o), 80'd0);

    // full with rd_i on the write cycle
    for (int i = 0; i < 4; i++) pulse(10, 6, tsv[i]);
    chk("t4_full", 80'(bus.cnt_o), 80'd4);
    pps_i = 1'b1;
    tsv[4] = rtc_std_i;
    tick(10);
    bus.rd_i = 1'b1;
    tick();
    bus.rd_i = 1'b0;
    chk("t4_cnt", 80'(bus.cnt_o), 80'd4);
    chk("t4_ovf", 80'(bus.ovf_o), 80'd0);
    chk("t4_irq", 80'(bus.irq_o), 80'd1);
    chk("t4_head", bus.ts_o, tsv[1]);
    tick(9);
    pps_i = 1'b0;
    tick(6);
    for (int i = 2; i < 5; i++) begin
      bus.rd_i = 1'b1;
      tick();
      bus.rd_i = 1'b0;
      chk("t4_pop_head", bus.ts_o, tsv[i]);
    end
    chk("t4_tail_cnt", 80'(bus.cnt_o), 80'd1);
    bus.rd_i = 1'b1;
    tick(2);
    bus.rd_i = 1'b0;
    chk("t4_empty_rd", 80'(bus.cnt_o), 80'd0);

    // pps stuck high across reset release; cap_en low while armed
    rst_n = 1'b0;
    pps_i = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    pps_i = 1'b0;
    tick(6);
    chk("t5_stuck_cnt", 80'(bus.cnt_o), 80'd0);
    pulse(10, 6, t);
    chk("t5_cnt", 80'(bus.cnt_o), 80'd1);
    chk("t5_ts", bus.ts_o, t);
    cap_en_i = 1'b0;
    tick(2);
    pulse(10, 6, t);
    cap_en_i = 1'b1;
    tick(4);
    chk("t5_dis_cnt", 80'(bus.cnt_o), 80'd1);
    chk("t5_dis_glitch", 80'(bus.glitch_cnt_o), 80'd0);
    pulse(3, 6, t);
    chk("t5_glitch", 80'(bus.glitch_cnt_o), 80'd1);

    // async reset in the middle of qualification
    pps_i = 1'b1;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld",    80'(bus.ts_vld_o),     80'd0);
    chk("t6_cnt",    80'(bus.cnt_o),        80'd0);
    chk("t6_glitch", 80'(bus.glitch_cnt_o), 80'd0);
    chk("t6_ovf",    80'(bus.ovf_o),        80'd0);
    chk("t6_irq",    80'(bus.irq_o),        80'd0);
    chk("t6_ts",     bus.ts_o,              80'd0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    pps_i = 1'b0;
    tick(6);
    chk("t6_no_stale", 80'(bus.cnt_o), 80'd0);
    pulse(10, 6, t);
    chk("t6_after_cnt", 80'(bus.cnt_o), 80'd1);
    chk("t6_after_ts", bus.ts_o, t);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
